// File: rtl/pool_8_4_pkg.sv
// Shared constants, FSM encoding and packing helper for the conv/pool pipeline stages.
// Maps are packed row-major with pixel (0,0) at the MSB end of the bus.
package pool_8_4_pkg;

    localparam int unsigned CONV_OUT_DIM = 8;
    localparam int unsigned POOL_OUT_DIM = 4;
    localparam int unsigned PIX_W        = 4;
    localparam int unsigned SUM_W        = 9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_POOL = 1'b1
    } pool_state_e;

    // LSB position of pixel (r,c) in a dim x dim map of w-bit pixels, row 0 at the MSB.
    function automatic int unsigned pix_lsb(input int unsigned w, input int unsigned dim,
                                            input int unsigned r, input int unsigned c);
        return w * (dim * dim - 1 - (dim * r + c));
    endfunction

endpackage

// File: rtl/pool_max4_quant.sv
// One 2x2 pooling window: unsigned max of four sums, right shift, saturate to the pixel width.
module pool_max4_quant
    import pool_8_4_pkg::*;
#(
    parameter int unsigned IN_W  = SUM_W,
    parameter int unsigned OUT_W = PIX_W,
    parameter int unsigned SHIFT = 5
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] q
);

    localparam logic [IN_W-1:0] PIX_MAX = IN_W'((1 << OUT_W) - 1);

    logic [IN_W-1:0] max_ab;
    logic [IN_W-1:0] max_cd;
    logic [IN_W-1:0] max_all;
    logic [IN_W-1:0] shifted;

    always_comb begin
        max_ab  = (a > b) ? a : b;
        max_cd  = (c > d) ? c : d;
        max_all = (max_ab > max_cd) ? max_ab : max_cd;
        shifted = max_all >> SHIFT;
        // Clamp rather than wrap so bright regions stay bright after requantisation.
        q = (shifted > PIX_MAX) ? PIX_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/pool_8_4.sv
// 2x2/stride-2 max-pool of an 8x8 sum map into a 4x4 map of requantised pixels.
// One pooled row per cycle; the finished map is published atomically with end_flag.
module pool_8_4
    import pool_8_4_pkg::*;
#(
    parameter int unsigned IN_W  = SUM_W,
    parameter int unsigned OUT_W = PIX_W,
    parameter int unsigned SHIFT = 5
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start_flag,
    input  logic [IN_W*CONV_OUT_DIM*CONV_OUT_DIM-1:0]    in,
    output logic [OUT_W*POOL_OUT_DIM*POOL_OUT_DIM-1:0]   out,
    output logic                                         end_flag
);

    localparam int unsigned IN_BITS  = IN_W * CONV_OUT_DIM * CONV_OUT_DIM;
    localparam int unsigned OUT_BITS = OUT_W * POOL_OUT_DIM * POOL_OUT_DIM;
    localparam int unsigned ROW_BITS = OUT_W * POOL_OUT_DIM;

    pool_state_e         state;
    logic [1:0]          row;
    logic [IN_BITS-1:0]  in_reg;
    logic [OUT_BITS-1:0] work_reg;
    logic [OUT_BITS-1:0] out_reg;
    logic                pulse_reg;

    int unsigned         row_i;
    logic [IN_W-1:0]     win [POOL_OUT_DIM][4];
    logic [OUT_W-1:0]    q   [POOL_OUT_DIM];
    logic [ROW_BITS-1:0] row_pix;
    logic [OUT_BITS-1:0] work_merged;

    assign row_i = 32'(row);

    // Select the two input rows feeding the active pooled row, one window per column.
    always_comb begin
        for (int unsigned j = 0; j < POOL_OUT_DIM; j++) begin
            win[j][0] = in_reg[pix_lsb(IN_W, CONV_OUT_DIM, 2 * row_i,     2 * j)     +: IN_W];
            win[j][1] = in_reg[pix_lsb(IN_W, CONV_OUT_DIM, 2 * row_i,     2 * j + 1) +: IN_W];
            win[j][2] = in_reg[pix_lsb(IN_W, CONV_OUT_DIM, 2 * row_i + 1, 2 * j)     +: IN_W];
            win[j][3] = in_reg[pix_lsb(IN_W, CONV_OUT_DIM, 2 * row_i + 1, 2 * j + 1) +: IN_W];
        end
    end

    for (genvar j = 0; j < POOL_OUT_DIM; j++) begin : g_col
        pool_max4_quant #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_max4 (
            .a (win[j][0]),
            .b (win[j][1]),
            .c (win[j][2]),
            .d (win[j][3]),
            .q (q[j])
        );
    end

    always_comb begin
        row_pix = '0;
        for (int unsigned j = 0; j < POOL_OUT_DIM; j++) begin
            row_pix[ROW_BITS - 1 - OUT_W * j -: OUT_W] = q[j];
        end
        work_merged = work_reg;
        work_merged[pix_lsb(OUT_W, POOL_OUT_DIM, row_i, POOL_OUT_DIM - 1) +: ROW_BITS] = row_pix;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            row       <= 2'd0;
            in_reg    <= '0;
            work_reg  <= '0;
            out_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_flag) begin
                        in_reg <= in;
                        row    <= 2'd0;
                        state  <= S_POOL;
                    end
                end
                S_POOL: begin
                    work_reg <= work_merged;
                    row      <= row + 2'd1;
                    // Last row goes straight to out so the map never appears half-built.
                    if (row == 2'd3) begin
                        out_reg   <= work_merged;
                        pulse_reg <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out      = out_reg;
    assign end_flag = pulse_reg;

endmodule
